// File: rtl/ad7606_par_ctrl_if.sv
// ============================================================================
// Module  : ad7606_par_if
// Brief   : Request, ADC pin and result bundle for the AD7606 parallel controller.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface ad7606_par_if;
    logic        i_cap_start;
    logic [2:0]  i_os_ratio;
    logic        i_ad_busy;
    logic [15:0] i_ad_data;
    logic        o_ad_reset;
    logic        o_ad_convst;
    logic        o_ad_cs_n;
    logic        o_ad_rd_n;
    logic [2:0]  o_ad_os;
    logic [15:0] o_user_data_1;
    logic [15:0] o_user_data_2;
    logic [15:0] o_user_data_3;
    logic [15:0] o_user_data_4;
    logic [15:0] o_user_data_5;
    logic [15:0] o_user_data_6;
    logic [15:0] o_user_data_7;
    logic [15:0] o_user_data_8;
    logic        o_user_valid_1;
    logic        o_user_valid_2;
    logic        o_user_valid_3;
    logic        o_user_valid_4;
    logic        o_user_valid_5;
    logic        o_user_valid_6;
    logic        o_user_valid_7;
    logic        o_user_valid_8;
    logic        o_ready;
    logic        o_timeout;

    // master: the controller; slave: the requester, chip and packer around it
    modport master (
        input  i_cap_start, i_os_ratio, i_ad_busy, i_ad_data,
        output o_ad_reset, o_ad_convst, o_ad_cs_n, o_ad_rd_n, o_ad_os,
        output o_user_data_1, o_user_data_2, o_user_data_3, o_user_data_4,
        output o_user_data_5, o_user_data_6, o_user_data_7, o_user_data_8,
        output o_user_valid_1, o_user_valid_2, o_user_valid_3, o_user_valid_4,
        output o_user_valid_5, o_user_valid_6, o_user_valid_7, o_user_valid_8,
        output o_ready, o_timeout
    );
    modport slave (
        output i_cap_start, i_os_ratio, i_ad_busy, i_ad_data,
        input  o_ad_reset, o_ad_convst, o_ad_cs_n, o_ad_rd_n, o_ad_os,
        input  o_user_data_1, o_user_data_2, o_user_data_3, o_user_data_4,
        input  o_user_data_5, o_user_data_6, o_user_data_7, o_user_data_8,
        input  o_user_valid_1, o_user_valid_2, o_user_valid_3, o_user_valid_4,
        input  o_user_valid_5, o_user_valid_6, o_user_valid_7, o_user_valid_8,
        input  o_ready, o_timeout
    );
endinterface

`default_nettype wire

// File: rtl/ad7606_par_ctrl.sv
// ============================================================================
// Module  : ad7606_par_ctrl
// Brief   : AD7606 16-bit parallel-mode sequencer: reset, CONVST, BUSY wait,
//           eight CS/RD reads, then one common valid for all channel words.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ad7606_par_ctrl #(
    parameter int P_RST_CYCLES   = 10,
    parameter int P_CONVST_LOW   = 4,
    parameter int P_RD_LOW       = 3,
    parameter int P_RD_HIGH      = 2,
    parameter int P_BUSY_TIMEOUT = 20000
) (
    input  wire logic         i_clk,
    input  wire logic         i_rst,
    ad7606_par_if.master      bus
);

    localparam logic [15:0] C_RST_LAST    = 16'(P_RST_CYCLES - 1);
    localparam logic [15:0] C_CONVST_LAST = 16'(P_CONVST_LOW - 1);
    localparam logic [15:0] C_RD_LOW_LAST = 16'(P_RD_LOW - 1);
    localparam logic [15:0] C_RD_HI_LAST  = 16'(P_RD_HIGH - 1);
    localparam logic [15:0] C_TO_LAST     = 16'(P_BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_IDLE   = 3'd1,
        S_CONVST = 3'd2,
        S_WAIT_H = 3'd3,
        S_WAIT_L = 3'd4,
        S_READ   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t      r_state_q;
    logic [15:0] r_cnt_q;
    logic [2:0]  r_word_q;
    logic        r_setup_q;
    logic        r_busy_meta_q;
    logic        r_busy_s_q;
    logic        r_busy_dly_q;
    logic [15:0] r_hold_q [8];
    logic [15:0] r_data_q [8];
    logic        r_ad_reset_q;
    logic        r_convst_q;
    logic        r_cs_n_q;
    logic        r_rd_n_q;
    logic [2:0]  r_os_q;
    logic        r_valid_q;
    logic        r_ready_q;
    logic        r_timeout_q;
    logic        w_busy_fall;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy_meta_q <= 1'b0;
            r_busy_s_q    <= 1'b0;
            r_busy_dly_q  <= 1'b0;
        end else begin
            r_busy_meta_q <= bus.i_ad_busy;
            r_busy_s_q    <= r_busy_meta_q;
            r_busy_dly_q  <= r_busy_s_q;
        end
    end

    assign w_busy_fall = r_busy_dly_q & ~r_busy_s_q;

    // One counter serves reset hold, CONVST width, BUSY timeout and RD phases.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q    <= S_RST;
            r_cnt_q      <= '0;
            r_word_q     <= '0;
            r_setup_q    <= 1'b0;
            r_ad_reset_q <= 1'b1;
            r_convst_q   <= 1'b1;
            r_cs_n_q     <= 1'b1;
            r_rd_n_q     <= 1'b1;
            r_os_q       <= '0;
            r_valid_q    <= 1'b0;
            r_ready_q    <= 1'b0;
            r_timeout_q  <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                r_hold_q[k] <= '0;
                r_data_q[k] <= '0;
            end
        end else begin
            r_timeout_q <= 1'b0;
            r_valid_q   <= 1'b0;
            case (r_state_q)
                S_RST: begin
                    if (r_cnt_q == C_RST_LAST) begin
                        r_ad_reset_q <= 1'b0;
                        r_ready_q    <= 1'b1;
                        r_cnt_q      <= '0;
                        r_state_q    <= S_IDLE;
                    end else begin
                        r_cnt_q <= r_cnt_q + 16'd1;
                    end
                end
                S_IDLE: begin
                    r_os_q <= bus.i_os_ratio;
                    if (bus.i_cap_start) begin
                        r_convst_q <= 1'b0;
                        r_ready_q  <= 1'b0;
                        r_cnt_q    <= '0;
                        r_state_q  <= S_CONVST;
                    end
                end
                S_CONVST: begin
                    if (r_cnt_q == C_CONVST_LAST) begin
                        r_convst_q <= 1'b1;
                        r_cnt_q    <= '0;
                        r_state_q  <= S_WAIT_H;
                    end else begin
                        r_cnt_q <= r_cnt_q + 16'd1;
                    end
                end
                S_WAIT_H, S_WAIT_L: begin
                    if (r_cnt_q == C_TO_LAST) begin
                        r_timeout_q <= 1'b1;
                        r_ready_q   <= 1'b1;
                        r_cnt_q     <= '0;
                        r_state_q   <= S_IDLE;
                    end else begin
                        r_cnt_q <= r_cnt_q + 16'd1;
                        if (r_state_q == S_WAIT_H && r_busy_s_q) begin
                            r_state_q <= S_WAIT_L;
                        end else if (r_state_q == S_WAIT_L && w_busy_fall) begin
                            r_cs_n_q  <= 1'b0;
                            r_setup_q <= 1'b1;
                            r_word_q  <= '0;
                            r_cnt_q   <= '0;
                            r_state_q <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (r_setup_q) begin
                        r_setup_q <= 1'b0;
                        r_rd_n_q  <= 1'b0;
                        r_cnt_q   <= '0;
                    end else if (!r_rd_n_q) begin
                        if (r_cnt_q == C_RD_LOW_LAST) begin
                            r_rd_n_q           <= 1'b1;
                            r_hold_q[r_word_q] <= bus.i_ad_data;
                            r_cnt_q            <= '0;
                        end else begin
                            r_cnt_q <= r_cnt_q + 16'd1;
                        end
                    end else if (r_cnt_q == C_RD_HI_LAST) begin
                        r_cnt_q  <= '0;
                        r_word_q <= r_word_q + 3'd1;
                        if (r_word_q == 3'd7) begin
                            r_cs_n_q  <= 1'b1;
                            r_valid_q <= 1'b1;
                            r_data_q  <= r_hold_q;
                            r_state_q <= S_DONE;
                        end else begin
                            r_rd_n_q <= 1'b0;
                        end
                    end else begin
                        r_cnt_q <= r_cnt_q + 16'd1;
                    end
                end
                S_DONE: begin
                    r_ready_q <= 1'b1;
                    r_state_q <= S_IDLE;
                end
                default: r_state_q <= S_RST;
            endcase
        end
    end

    assign bus.o_ad_reset     = r_ad_reset_q;
    assign bus.o_ad_convst    = r_convst_q;
    assign bus.o_ad_cs_n      = r_cs_n_q;
    assign bus.o_ad_rd_n      = r_rd_n_q;
    assign bus.o_ad_os        = r_os_q;
    assign bus.o_ready        = r_ready_q;
    assign bus.o_timeout      = r_timeout_q;
    assign bus.o_user_data_1  = r_data_q[0];
    assign bus.o_user_data_2  = r_data_q[1];
    assign bus.o_user_data_3  = r_data_q[2];
    assign bus.o_user_data_4  = r_data_q[3];
    assign bus.o_user_data_5  = r_data_q[4];
    assign bus.o_user_data_6  = r_data_q[5];
    assign bus.o_user_data_7  = r_data_q[6];
    assign bus.o_user_data_8  = r_data_q[7];
    assign bus.o_user_valid_1 = r_valid_q;
    assign bus.o_user_valid_2 = r_valid_q;
    assign bus.o_user_valid_3 = r_valid_q;
    assign bus.o_user_valid_4 = r_valid_q;
    assign bus.o_user_valid_5 = r_valid_q;
    assign bus.o_user_valid_6 = r_valid_q;
    assign bus.o_user_valid_7 = r_valid_q;
    assign bus.o_user_valid_8 = r_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_ad7606_par_ctrl.sv
// ============================================================================
// Module  : tb_ad7606_par_ctrl
// Brief   : Directed bench for ad7606_par_ctrl with BUSY and DB chip models.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ad7606_par_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    ad7606_par_if bus ();

    ad7606_par_ctrl #(
        .P_RST_CYCLES  (10),
        .P_CONVST_LOW  (4),
        .P_RD_LOW      (3),
        .P_RD_HIGH     (2),
        .P_BUSY_TIMEOUT(20000)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int nvec = 0;
    int nerr = 0;

    logic [15:0] ud [8];
    logic [7:0]  uv;
    assign ud[0] = bus.o_user_data_1;
    assign ud[1] = bus.o_user_data_2;
    assign ud[2] = bus.o_user_data_3;
    assign ud[3] = bus.o_user_data_4;
    assign ud[4] = bus.o_user_data_5;
    assign ud[5] = bus.o_user_data_6;
    assign ud[6] = bus.o_user_data_7;
    assign ud[7] = bus.o_user_data_8;
    assign uv = {bus.o_user_valid_8, bus.o_user_valid_7, bus.o_user_valid_6, bus.o_user_valid_5,
                 bus.o_user_valid_4, bus.o_user_valid_3, bus.o_user_valid_2, bus.o_user_valid_1};

    // BUSY: high 3 cycles after CONVST rises, low again 200 cycles later
    bit busy_en = 1'b0;
    always @(posedge bus.o_ad_convst) begin
        if (busy_en) begin
            repeat (3) @(posedge clk);
            #1 bus.i_ad_busy = 1'b1;
            repeat (200) @(posedge clk);
            #1 bus.i_ad_busy = 1'b0;
        end
    end

    // DB: word k of a burst reads k*16'h1001 + db_off
    logic [15:0] db_off = 16'h0000;
    int          db_idx = 0;
    always @(negedge bus.o_ad_rd_n) begin
        bus.i_ad_data = 16'(db_idx + 1) * 16'h1001 + db_off;
        db_idx++;
    end

    int n_cv_low, n_setup, n_rd, n_valid, n_vmix, n_to, to_cyc, cv_rise_cyc, ready_cyc, last_hi, os_bad;
    int lo_len [8];
    int hi_len [8];
    logic [2:0] os_first;
    bit done_ok;

    task automatic run_conv(input int budget, input bit spam, input int os_cyc, input logic [2:0] os_new);
        int lo_run, hi_run;
        logic prev_rd, prev_cv;
        n_cv_low = 0; n_setup = 0; n_rd = 0; n_valid = 0; n_vmix = 0; n_to = 0;
        to_cyc = 0; cv_rise_cyc = 0; ready_cyc = 0; last_hi = 0; os_bad = 0;
        lo_run = 0; hi_run = 0; prev_rd = 1'b1; prev_cv = 1'b1; done_ok = 1'b0; db_idx = 0;
        for (int k = 0; k < 8; k++) begin lo_len[k] = 0; hi_len[k] = 0; end
        @(negedge clk);
        bus.i_cap_start = 1'b1;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            if (cyc == 1) os_first = bus.o_ad_os;
            if (!bus.o_ad_convst) n_cv_low++;
            if (bus.o_ad_convst && !prev_cv) cv_rise_cyc = cyc;
            prev_cv = bus.o_ad_convst;
            if (bus.o_timeout) begin n_to++; to_cyc = cyc; end
            if (!bus.o_ad_cs_n && bus.o_ad_rd_n && n_rd == 0) n_setup++;
            if (!bus.o_ad_rd_n) begin
                if (prev_rd) begin
                    n_rd++;
                    if (n_rd >= 2 && n_rd <= 8) hi_len[n_rd-2] = hi_run;
                    lo_run = 0;
                end
                lo_run++;
            end else begin
                if (!prev_rd) begin
                    if (n_rd >= 1 && n_rd <= 8) lo_len[n_rd-1] = lo_run;
                    hi_run = 0;
                end
                if (!bus.o_ad_cs_n) hi_run++;
            end
            prev_rd = bus.o_ad_rd_n;
            if (uv != 8'h00) begin
                n_valid++;
                last_hi = hi_run;
                if (uv != 8'hFF) n_vmix++;
            end
            if (!bus.o_ready && bus.o_ad_os != os_first) os_bad++;
            if (bus.o_ready && ready_cyc == 0) ready_cyc = cyc;
            bus.i_cap_start = spam && (!bus.o_ad_cs_n || uv != 8'h00);
            if (cyc == os_cyc) bus.i_os_ratio = os_new;
            if (ready_cyc != 0 && cyc >= ready_cyc + 2) begin
                done_ok = 1'b1;
                break;
            end
        end
        bus.i_cap_start = 1'b0;
    endtask

    task automatic test_reset();
        int hi_cnt;
        repeat (3) @(negedge clk);
        nvec++; if (bus.o_ad_reset !== 1'b1) begin nerr++; $display("FAIL rst_ad_reset: got %b want 1", bus.o_ad_reset); end
        nvec++; if ({bus.o_ad_convst, bus.o_ad_cs_n, bus.o_ad_rd_n} !== 3'b111) begin nerr++; $display("FAIL rst_strobes: got %b want 111", {bus.o_ad_convst, bus.o_ad_cs_n, bus.o_ad_rd_n}); end
        nvec++; if ({bus.o_ad_os, bus.o_ready, bus.o_timeout, uv} !== 13'd0) begin nerr++; $display("FAIL rst_os_ready_to_valid: got %h want 0", {bus.o_ad_os, bus.o_ready, bus.o_timeout, uv}); end
        nvec++; if ((ud[0] | ud[3] | ud[7]) !== 16'h0000) begin nerr++; $display("FAIL rst_data: got %h want 0000", ud[0] | ud[3] | ud[7]); end
        rst = 1'b0;
        hi_cnt = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.o_ad_reset) hi_cnt++; else break;
        end
        nvec++; if (hi_cnt !== 10) begin nerr++; $display("FAIL rst_hold_cycles: got %0d want 10", hi_cnt); end
        nvec++; if (bus.o_ready !== 1'b1) begin nerr++; $display("FAIL rst_ready: got %b want 1", bus.o_ready); end
    endtask

    task automatic test_nominal();
        busy_en = 1'b1;
        db_off = 16'h0000;
        run_conv(600, 1'b0, 0, 3'b000);
        nvec++; if (done_ok !== 1'b1) begin nerr++; $display("FAIL nom_complete: got %b want 1", done_ok); end
        nvec++; if (n_cv_low !== 4) begin nerr++; $display("FAIL nom_convst_low: got %0d want 4", n_cv_low); end
        nvec++; if (n_setup !== 1) begin nerr++; $display("FAIL nom_cs_setup: got %0d want 1", n_setup); end
        nvec++; if (n_rd !== 8) begin nerr++; $display("FAIL nom_rd_pulses: got %0d want 8", n_rd); end
        for (int k = 0; k < 8; k++) begin
            nvec++; if (lo_len[k] !== 3) begin nerr++; $display("FAIL nom_rd_low[%0d]: got %0d want 3", k, lo_len[k]); end
        end
        for (int k = 0; k < 7; k++) begin
            nvec++; if (hi_len[k] !== 2) begin nerr++; $display("FAIL nom_rd_high[%0d]: got %0d want 2", k, hi_len[k]); end
        end
        nvec++; if (last_hi !== 2) begin nerr++; $display("FAIL nom_last_high: got %0d want 2", last_hi); end
        nvec++; if (n_valid !== 1 || n_vmix !== 0) begin nerr++; $display("FAIL nom_valid: got %0d cycles %0d mixed want 1 0", n_valid, n_vmix); end
        for (int k = 0; k < 8; k++) begin
            nvec++; if (ud[k] !== 16'(k + 1) * 16'h1001) begin nerr++; $display("FAIL nom_data[%0d]: got %h want %h", k + 1, ud[k], 16'(k + 1) * 16'h1001); end
        end
        nvec++; if (n_to !== 0) begin nerr++; $display("FAIL nom_no_timeout: got %0d want 0", n_to); end
    endtask

    task automatic test_timeout();
        busy_en = 1'b0;
        run_conv(20100, 1'b0, 0, 3'b000);
        nvec++; if (done_ok !== 1'b1) begin nerr++; $display("FAIL to_complete: got %b want 1", done_ok); end
        nvec++; if (n_to !== 1) begin nerr++; $display("FAIL to_pulse_width: got %0d want 1", n_to); end
        nvec++; if (to_cyc - cv_rise_cyc !== 20000) begin nerr++; $display("FAIL to_latency: got %0d want 20000", to_cyc - cv_rise_cyc); end
        nvec++; if (ready_cyc !== to_cyc) begin nerr++; $display("FAIL to_ready: got cycle %0d want %0d", ready_cyc, to_cyc); end
        nvec++; if (n_valid !== 0 || n_rd !== 0) begin nerr++; $display("FAIL to_no_read: got %0d valid %0d rd want 0 0", n_valid, n_rd); end
        nvec++; if (ud[0] !== 16'h1001 || ud[7] !== 16'h8008) begin nerr++; $display("FAIL to_data_kept: got %h %h want 1001 8008", ud[0], ud[7]); end
    endtask

    task automatic test_ignored_start();
        int extra_low;
        busy_en = 1'b1;
        db_off = 16'h0010;
        run_conv(600, 1'b1, 0, 3'b000);
        nvec++; if (done_ok !== 1'b1 || n_valid !== 1) begin nerr++; $display("FAIL ign_one_valid: got done %b valid %0d want 1 1", done_ok, n_valid); end
        nvec++; if (ud[0] !== 16'h1011 || ud[7] !== 16'h8018) begin nerr++; $display("FAIL ign_data: got %h %h want 1011 8018", ud[0], ud[7]); end
        extra_low = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (!bus.o_ad_convst || !bus.o_ready) extra_low++;
        end
        nvec++; if (extra_low !== 0) begin nerr++; $display("FAIL ign_not_queued: got %0d busy cycles want 0", extra_low); end
    endtask

    task automatic test_os_latch();
        busy_en = 1'b1;
        db_off = 16'h0100;
        bus.i_os_ratio = 3'b011;
        repeat (2) @(negedge clk);
        nvec++; if (bus.o_ad_os !== 3'b011) begin nerr++; $display("FAIL os_idle: got %b want 011", bus.o_ad_os); end
        run_conv(600, 1'b0, 20, 3'b101);
        nvec++; if (os_bad !== 0) begin nerr++; $display("FAIL os_held_busy: got %0d changes want 0", os_bad); end
        nvec++; if (bus.o_ad_os !== 3'b101) begin nerr++; $display("FAIL os_after_idle: got %b want 101", bus.o_ad_os); end
        nvec++; if (ud[3] !== 16'h4104) begin nerr++; $display("FAIL os_conv_data: got %h want 4104", ud[3]); end
    endtask

    task automatic test_mid_read_reset();
        int rises, vcnt, hi_cnt;
        logic prev;
        busy_en = 1'b1;
        db_off = 16'h0200;
        db_idx = 0;
        rises = 0; vcnt = 0; prev = 1'b1;
        @(negedge clk);
        bus.i_cap_start = 1'b1;
        @(negedge clk);
        bus.i_cap_start = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (bus.o_ad_rd_n && !prev) rises++;
            prev = bus.o_ad_rd_n;
            if (uv != 8'h00) vcnt++;
            if (rises == 4) break;
        end
        nvec++; if (rises !== 4) begin nerr++; $display("FAIL mrr_reach_4th: got %0d want 4", rises); end
        rst = 1'b1;
        @(negedge clk);
        nvec++; if ({bus.o_ad_cs_n, bus.o_ad_rd_n, bus.o_ad_convst, bus.o_ad_reset} !== 4'b1111) begin nerr++; $display("FAIL mrr_pins: got %b want 1111", {bus.o_ad_cs_n, bus.o_ad_rd_n, bus.o_ad_convst, bus.o_ad_reset}); end
        nvec++; if (bus.o_ready !== 1'b0 || ud[0] !== 16'h0000) begin nerr++; $display("FAIL mrr_clear: got ready %b data %h want 0 0000", bus.o_ready, ud[0]); end
        @(negedge clk);
        rst = 1'b0;
        hi_cnt = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (uv != 8'h00) vcnt++;
            if (bus.o_ad_reset) hi_cnt++; else break;
        end
        nvec++; if (hi_cnt !== 10 || bus.o_ready !== 1'b1) begin nerr++; $display("FAIL mrr_rst_seq: got %0d cycles ready %b want 10 1", hi_cnt, bus.o_ready); end
        repeat (5) begin
            @(negedge clk);
            if (uv != 8'h00) vcnt++;
        end
        nvec++; if (vcnt !== 0) begin nerr++; $display("FAIL mrr_no_valid: got %0d want 0", vcnt); end
    endtask

    initial begin
        bus.i_cap_start = 1'b0;
        bus.i_os_ratio  = 3'b000;
        bus.i_ad_busy   = 1'b0;
        bus.i_ad_data   = 16'h0000;
        test_reset();
        test_nominal();
        test_timeout();
        test_ignored_start();
        test_os_latch();
        test_mid_read_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion want completion by 2 ms");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
